mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words in the backing store (power of two, 16..1024).
REQ-002 SHALL have parameter LATENCY, default 2, meaning edges from request acceptance to response (1..15).
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data.
REQ-009 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-010 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port resp_rdata  output  32  load data, held between responses.
REQ-012 SHALL have port resp_error  output  1  request was misaligned or out of range, valid with resp_valid.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = (state == IDLE), decoded combinationally from state only.
REQ-014 SHALL accept a request at a rising edge where req_valid & req_ready; latch req_write, req_addr, req_wdata at that edge; later input changes ignored.
REQ-015 SHALL transition IDLE->RESP on acceptance when LATENCY = 1, else IDLE->WAIT with wait counter loaded to LATENCY-2.
REQ-016 SHALL decrement wait counter each WAIT cycle and transition WAIT->RESP when counter = 0.
REQ-017 SHALL hold resp_valid high for exactly the one cycle in RESP, then transition RESP->IDLE unconditionally; accepted-to-resp_valid rise = LATENCY edges.
REQ-018 SHALL ignore req_valid while not in IDLE; no queuing, no second outstanding request.
REQ-019 SHALL flag error when req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH; error requests perform no memory access.
REQ-020 SHALL, for error response, drive resp_error=1 and resp_rdata=0.
REQ-021 SHALL, for valid load, load resp_rdata with mem[req_addr[31:2]] at the edge entering RESP, resp_error=0.
REQ-022 SHALL, for valid store, write req_wdata to mem[index] at the edge entering RESP; resp_rdata unchanged, resp_error=0.
REQ-023 SHALL hold resp_rdata stable from one response until the next load or error response (downstream register may sample on either clock phase).
REQ-024 SHALL return newly written data for a load to the same word issued immediately after a store.
REQ-025 SHALL hold resp_error at last value outside RESP; consumers qualify with resp_valid.

Reset
REQ-026 SHALL, when reset is high at a rising edge: state=IDLE, wait counter=0, resp_valid=0, resp_error=0, resp_rdata=0; reset overrides acceptance and all transitions.
REQ-027 SHALL drop an in-flight request on reset mid-operation; a store whose commit edge coincides with reset SHALL NOT write memory.
REQ-028 SHALL NOT reset memory contents; array initialises to zero at simulation start only.

Structure
REQ-029 SHALL place the state enum, default DEPTH/LATENCY constants and the error-check address width in shared package mem_pkg.
REQ-030 SHALL instantiate one sub-module word_ram: DEPTH x 32, synchronous write, asynchronous read, single port.

Verification
REQ-031 Reset, then load 0x0000_0010 with LATENCY=2 -> req_ready low 2 cycles, resp_valid one cycle 2 edges after accept, resp_rdata=0, resp_error=0.
REQ-032 Store 0xDEAD_BEEF to 0x0000_0020, then load 0x0000_0020 -> second response resp_rdata=0xDEAD_BEEF; store response leaves resp_rdata unchanged.
REQ-033 Load 0x0000_0022 (misaligned) and 0x0000_0100 with DEPTH=64 -> resp_error=1, resp_rdata=0, memory unchanged on later readback.
REQ-034 Hold req_valid high continuously with changing addresses -> accepts only in IDLE, one request per LATENCY+1 cycles, each response matches the address latched at acceptance.
REQ-035 Issue store 0x1234_5678 to 0x0000_0004, assert reset on its commit edge -> outputs zero, state IDLE, later load of 0x0000_0004 returns prior contents.
REQ-036 Repeat REQ-031 with LATENCY=1 and LATENCY=15 -> resp_valid rises exactly 1 and 15 edges after acceptance.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants, state encodings and the address-legality check for mem_responder.
package mem_pkg;

  localparam int DEF_DEPTH   = 64;
  localparam int DEF_LATENCY = 2;
  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int CNT_W       = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // A request is illegal when it is not word aligned or its word index falls outside the store
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    logic [ADDR_W-3:0] word_idx;
    word_idx = addr[ADDR_W-1:2];
    return (addr[1:0] != 2'b00) || (word_idx >= (ADDR_W-2)'(depth));
  endfunction

endpackage

// File: rtl/mem_responder_word_ram.sv
// Single-port word store: synchronous write, asynchronous read, never reset.
module word_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = $clog2(DEF_DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a fixed request-to-response latency.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_error
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              accept;

  logic              lat_write;
  logic              lat_err;
  logic [IDX_W-1:0]  lat_idx;
  logic [WORD_W-1:0] lat_wdata;

  logic              commit;
  logic              c_write;
  logic              c_err;
  logic [IDX_W-1:0]  c_idx;
  logic [WORD_W-1:0] c_wdata;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_valid && req_ready;

  // Request capture: data path only, control reset covers the rest
  always_ff @(posedge clock) begin
    if (accept) begin
      lat_write <= req_write;
      lat_err   <= addr_err(req_addr, DEPTH);
      lat_idx   <= req_addr[IDX_W+1:2];
      lat_wdata <= req_wdata;
    end
  end

  // With single-edge latency the commit edge is the acceptance edge, so use live inputs
  always_comb begin
    commit  = (state == ST_WAIT) && (wait_cnt == '0);
    c_write = lat_write;
    c_err   = lat_err;
    c_idx   = lat_idx;
    c_wdata = lat_wdata;
    if (LATENCY == 1) begin
      commit  = accept;
      c_write = req_write;
      c_err   = addr_err(req_addr, DEPTH);
      c_idx   = req_addr[IDX_W+1:2];
      c_wdata = req_wdata;
    end
  end

  assign ram_we = commit && c_write && !c_err && !reset;

  word_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_word_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (c_idx),
    .wdata (c_wdata),
    .rdata (ram_rdata)
  );

  // Control FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= CNT_W'(LATENCY - 2);
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response registers hold between responses; stores leave read data untouched
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else if (commit) begin
      resp_error <= c_err;
      if (c_err) begin
        resp_rdata <= '0;
      end else if (!c_write) begin
        resp_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 2, 15) checked against a word-array model.
module tb_mem_responder;

  localparam int NI = 3;
  localparam int LAT [NI] = '{1, 2, 15};
  localparam int DEPTH = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid  [NI];
  logic        req_write  [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        req_ready  [NI];
  logic        resp_valid [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_error [NI];

  logic [31:0] mem_m   [NI][DEPTH];
  logic [31:0] rdata_m [NI];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]));

  mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]));

  mem_responder #(.DEPTH(DEPTH), .LATENCY(15)) dut2 (
    .clock(clock), .reset(reset), .req_valid(req_valid[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]));

  // Reference behaviour: illegal requests answer zero with error, stores update the word, loads return it
  task automatic model_apply(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                             output logic exp_err, output logic [31:0] exp_rd);
    exp_err = (a % 4 != 0) || (a / 4 >= DEPTH);
    if (exp_err) rdata_m[d] = 32'h0;
    else if (w) mem_m[d][a / 4] = wd;
    else rdata_m[d] = mem_m[d][a / 4];
    exp_rd = rdata_m[d];
  endtask

  task automatic do_req(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic exp_err;
    logic [31:0] exp_rd;
    @(negedge clock);
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL ready_timeout inst=%0d ready=%b required 1", d, req_ready[d]);
    end
    @(negedge clock);
    req_valid[d] = 1'b0; req_write[d] = 1'($urandom_range(0, 1));
    req_addr[d] = $urandom; req_wdata[d] = $urandom;
    n = 1;
    while (resp_valid[d] !== 1'b1 && n < 40) begin
      checks++;
      if (req_ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready inst=%0d got %b required 0", d, req_ready[d]);
      end
      @(negedge clock);
      n++;
    end
    model_apply(d, w, a, wd, exp_err, exp_rd);
    checks++;
    if (n !== LAT[d]) begin
      errors++;
      $display("FAIL latency inst=%0d addr=%h got %0d edges required %0d", d, a, n, LAT[d]);
    end
    checks++;
    if (resp_rdata[d] !== exp_rd) begin
      errors++;
      $display("FAIL rdata inst=%0d w=%0d addr=%h got %h required %h", d, w, a, resp_rdata[d], exp_rd);
    end
    checks++;
    if (resp_error[d] !== exp_err) begin
      errors++;
      $display("FAIL error inst=%0d addr=%h got %b required %b", d, a, resp_error[d], exp_err);
    end
    @(negedge clock);
    checks++;
    if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || resp_rdata[d] !== exp_rd) begin
      errors++;
      $display("FAIL after_resp inst=%0d valid=%b ready=%b rdata=%h required 0/1/%h",
               d, resp_valid[d], req_ready[d], resp_rdata[d], exp_rd);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    for (int d = 0; d < NI; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'h0 ||
          resp_error[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s inst=%0d ready=%b valid=%b rdata=%h error=%b required 1/0/0/0",
                 tag, d, req_ready[d], resp_valid[d], resp_rdata[d], resp_error[d]);
      end
      rdata_m[d] = 32'h0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle_zero("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_basic_load();
    for (int d = 0; d < NI; d++) do_req(d, 1'b0, 32'h0000_0010, 32'h0);
  endtask

  task automatic test_store_load();
    for (int d = 0; d < NI; d++) begin
      do_req(d, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
      do_req(d, 1'b0, 32'h0000_0020, 32'h0);
      do_req(d, 1'b1, 32'h0000_0024, 32'h0BAD_F00D);
    end
  endtask

  task automatic test_errors();
    for (int d = 0; d < NI; d++) begin
      do_req(d, 1'b0, 32'h0000_0022, 32'h0);
      do_req(d, 1'b0, 32'h0000_0100, 32'h0);
      do_req(d, 1'b1, 32'h0000_0100, 32'h1111_1111);
      do_req(d, 1'b1, 32'h0000_0022, 32'h2222_2222);
      do_req(d, 1'b1, 32'hFFFF_FFFC, 32'h3333_3333);
      do_req(d, 1'b0, 32'h0000_0000, 32'h0);
      do_req(d, 1'b0, 32'h0000_0020, 32'h0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int d;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      do_req(d, 1'($urandom_range(0, 1)), a, $urandom);
    end
    for (int i = 0; i < 4; i++) do_req(2, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) * 4, $urandom);
  endtask

  task automatic test_back_to_back(input int d);
    int acc_t, prev_acc, nacc;
    bit pend, pw;
    logic [31:0] pa, pwd, exp_rd;
    logic exp_err;
    pend = 0; prev_acc = -1; nacc = 0; acc_t = 0; pw = 0; pa = 0; pwd = 0;
    for (int t = 0; t < 140; t++) begin
      @(negedge clock);
      if (resp_valid[d] === 1'b1) begin
        checks++;
        if (!pend || t !== acc_t + LAT[d]) begin
          errors++;
          $display("FAIL b2b_timing inst=%0d resp at %0d, pending=%0d required at %0d", d, t, pend, acc_t + LAT[d]);
        end else begin
          model_apply(d, pw, pa, pwd, exp_err, exp_rd);
          checks++;
          if (resp_rdata[d] !== exp_rd || resp_error[d] !== exp_err) begin
            errors++;
            $display("FAIL b2b_data inst=%0d addr=%h got %h/%b required %h/%b",
                     d, pa, resp_rdata[d], resp_error[d], exp_rd, exp_err);
          end
        end
        pend = 0;
      end
      req_valid[d] = (t < 110);
      req_write[d] = 1'($urandom_range(0, 1));
      req_addr[d]  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 15)) * 4;
      req_wdata[d] = $urandom;
      if (req_ready[d] === 1'b1 && req_valid[d]) begin
        if (prev_acc >= 0) begin
          checks++;
          if (t - prev_acc !== LAT[d] + 1) begin
            errors++;
            $display("FAIL b2b_gap inst=%0d got %0d cycles required %0d", d, t - prev_acc, LAT[d] + 1);
          end
        end
        prev_acc = t; acc_t = t; pend = 1; nacc++;
        pw = req_write[d]; pa = req_addr[d]; pwd = req_wdata[d];
      end
    end
    req_valid[d] = 1'b0;
    checks++;
    if (pend || nacc < 3) begin
      errors++;
      $display("FAIL b2b_drain inst=%0d pending=%0d accepts=%0d required 0 pending, >=3 accepts", d, pend, nacc);
    end
  endtask

  task automatic test_reset_on_commit();
    do_req(1, 1'b1, 32'h0000_0004, 32'hA5A5_0001);
    @(negedge clock);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h0000_0004; req_wdata[1] = 32'h1234_5678;
    @(negedge clock);
    req_valid[1] = 1'b0; req_addr[1] = 32'h0; req_wdata[1] = 32'h0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle_zero("reset_commit");
    do_req(1, 1'b0, 32'h0000_0004, 32'h0);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clock);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h0000_0008; req_wdata[2] = 32'h5555_AAAA;
    @(negedge clock);
    req_valid[2] = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle_zero("reset_mid_wait");
    repeat (20) begin
      @(negedge clock);
      checks++;
      if (resp_valid[2] !== 1'b0) begin
        errors++;
        $display("FAIL dropped_resp inst=2 got valid %b required 0", resp_valid[2]);
      end
    end
    do_req(2, 1'b0, 32'h0000_0008, 32'h0);
  endtask

  initial begin
    for (int d = 0; d < NI; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
      rdata_m[d] = 32'h0;
      for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 32'h0;
    end
    reset = 1'b1;
    test_reset();
    test_basic_load();
    test_store_load();
    test_errors();
    test_random();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    test_reset_on_commit();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
